// File: rtl/evote_pkg.sv
// Shared definitions for the e-voting datapath: session state encoding and
// the default timebase figures, so tally and display logic agree with the timer.
package evote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_CLOSED = 2'd2
    } stateT;

    localparam int DEF_TICKS_PER_SEC = 100;
    localparam int DEF_SESSION_SECS  = 60;

endpackage

// File: rtl/voting_session_timer_if.sv
// Control/status bundle between the session controller and the voting timer.
// The master drives the session commands; the slave (the timer) reports status.
interface voting_session_timer_if #(
    parameter int SEC_W = 8
);
    logic             START;
    logic             ABORT;
    logic             CLEAR;
    logic             VOTE_EN;
    logic             TICK_1S;
    logic [SEC_W-1:0] SECS_LEFT;
    logic             DONE;
    logic             ABORTED;

    modport master (
        output START, ABORT, CLEAR,
        input  VOTE_EN, TICK_1S, SECS_LEFT, DONE, ABORTED
    );

    modport slave (
        input  START, ABORT, CLEAR,
        output VOTE_EN, TICK_1S, SECS_LEFT, DONE, ABORTED
    );
endinterface

// File: rtl/tick_prescaler.sv
// Wrap counter that divides CLK down to one TICK per TICKS enabled cycles.
// TICK is a decode of the counter register gated by EN, so it drops in the
// very first cycle EN goes low and never depends on an input combinationally.
module tick_prescaler #(
    parameter int TICKS = 100
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);
    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count;

    // Count enabled cycles 0..TICKS-1, parking at zero whenever disabled or cleared
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count <= '0;
        end else if (CLR || !EN) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign TICK = EN && (count == LAST);

endmodule

// File: rtl/voting_session_timer.sv
// Voting session timebase: opens a session on START, counts it down in
// whole seconds, and closes it on expiry or ABORT. VOTE_EN gates ballots.
module voting_session_timer
    import evote_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int SESSION_SECS  = DEF_SESSION_SECS,
    parameter int SEC_W         = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    voting_session_timer_if.slave bus
);
    // Reject parameter sets the counters cannot represent
    if (SESSION_SECS > (2 ** SEC_W) - 1 || SESSION_SECS < 1) begin : gBadSessionSecs
        $error("voting_session_timer: SESSION_SECS=%0d does not fit SEC_W=%0d", SESSION_SECS, SEC_W);
    end
    if (TICKS_PER_SEC < 2) begin : gBadTicks
        $error("voting_session_timer: TICKS_PER_SEC=%0d must be at least 2", TICKS_PER_SEC);
    end

    stateT            state;
    stateT            stateNext;
    logic [SEC_W-1:0] secsLeft;
    logic [SEC_W-1:0] secsNext;
    logic             done;
    logic             doneNext;
    logic             aborted;
    logic             abortedNext;
    logic             preClr;
    logic             tick;

    tick_prescaler #(
        .TICKS (TICKS_PER_SEC)
    ) uPrescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (state == ST_OPEN),
        .CLR   (preClr),
        .TICK  (tick)
    );

    // Register the FSM state together with the countdown and status flags
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            secsLeft <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= stateNext;
            secsLeft <= secsNext;
            done     <= doneNext;
            aborted  <= abortedNext;
        end
    end

    // Next-state logic; an abort coinciding with the final tick still lands on zero
    always_comb begin
        stateNext   = state;
        secsNext    = secsLeft;
        doneNext    = 1'b0;
        abortedNext = aborted;
        preClr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.START) begin
                    stateNext   = ST_OPEN;
                    secsNext    = SEC_W'(SESSION_SECS);
                    abortedNext = 1'b0;
                    preClr      = 1'b1;
                end
            end
            ST_OPEN: begin
                if (tick && secsLeft != '0) begin
                    secsNext = secsLeft - SEC_W'(1);
                end
                if (bus.ABORT) begin
                    stateNext   = ST_CLOSED;
                    doneNext    = 1'b1;
                    abortedNext = 1'b1;
                end else if (tick && secsLeft <= SEC_W'(1)) begin
                    stateNext = ST_CLOSED;
                    doneNext  = 1'b1;
                end
            end
            ST_CLOSED: begin
                if (bus.CLEAR) begin
                    stateNext = ST_IDLE;
                    secsNext  = '0;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                secsNext  = '0;
            end
        endcase
    end

    assign bus.VOTE_EN   = (state == ST_OPEN);
    assign bus.TICK_1S   = tick;
    assign bus.SECS_LEFT = secsLeft;
    assign bus.DONE      = done;
    assign bus.ABORTED   = aborted;

endmodule

// File: tb/tb_voting_session_timer.sv
// Directed bench for voting_session_timer with TICKS_PER_SEC=4, SESSION_SECS=3.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_voting_session_timer;

    localparam int TPS = 4;
    localparam int SS  = 3;

    logic CLK;
    logic RST_N;
    int   total;
    int   bad;

    voting_session_timer_if #(.SEC_W(8)) bus ();

    voting_session_timer #(
        .TICKS_PER_SEC (TPS),
        .SESSION_SECS  (SS),
        .SEC_W         (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // clockGen: free-running 10-unit clock feeding the timer
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected seconds remaining in session cycle c (cycle 1 follows the START edge)
    function automatic logic [7:0] secsModel(input int c);
        int v;
        if (c > SS * TPS) v = 0;
        else v = SS - (c - 1) / TPS;
        return 8'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic eVote, input logic eTick,
                            input logic [7:0] eSecs, input logic eDone, input logic eAborted);
        checkOutput({tag, " vote"},    32'(bus.VOTE_EN),   32'(eVote));
        checkOutput({tag, " tick"},    32'(bus.TICK_1S),   32'(eTick));
        checkOutput({tag, " secs"},    32'(bus.SECS_LEFT), 32'(eSecs));
        checkOutput({tag, " done"},    32'(bus.DONE),      32'(eDone));
        checkOutput({tag, " aborted"}, 32'(bus.ABORTED),   32'(eAborted));
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic c);
        bus.START = s;
        bus.ABORT = a;
        bus.CLEAR = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        bus.START = 1'b1;
        bus.ABORT = 1'b0;
        bus.CLEAR = 1'b0;

        // reset held for three edges with START high
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkAll($sformatf("reset e%0d", i), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        end
        RST_N = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("post reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // full session
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            checkAll($sformatf("full c%0d", c), c <= SS * TPS, (c % TPS == 0) && (c <= SS * TPS),
                     secsModel(c), c == SS * TPS + 1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end

        // abort mid-session at the edge ending cycle 6
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 6; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("abt c6", 1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("abt c7", 1'b0, 1'b0, 8'd2, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("abt c8", 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAll("abt clr", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAll("abt restart", 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);

        // abort on the final tick edge
        for (int c = 1; c < 12; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("fin c12", 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("fin c13", 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("fin c14", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);

        // ignored inputs: ABORT in IDLE, START/CLEAR during OPEN, START+CLEAR in CLOSED
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("idle abort", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            checkAll($sformatf("ign c%0d", c), 1'b1, c % TPS == 0, secsModel(c), 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkAll("ign c13", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkAll("ign idle", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("ign stay", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // reset at the edge ending cycle 5
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("rst c5", 1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        RST_N = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("rst c6", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        RST_N = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkAll($sformatf("rst after %0d", i), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voting_session_timer.md
# voting_session_timer

Clock-consuming timebase for the e-voting datapath: sits directly downstream of the `ClockGen` clock source. It divides `CLK` into a one-second tick and runs a voting-session countdown. It gates ballot acceptance through `VOTE_EN` and signals session end to the tally/display logic.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100: `CLK` cycles per second tick. Legal range is ≥2.
- `SESSION_SECS`, default 60: session length in seconds. Legal range is 1..255.
- `SEC_W`, default 8: width of `SECS_LEFT`.

Ports:
- `CLK`, input, 1: sole clock. Everything is rising-edge.
- `RST_N`, input, 1: reset, synchronous, active-low.
- `START`, input, 1: level, sampled each edge. Opens a session from IDLE.
- `ABORT`, input, 1: level. Force-closes an open session.
- `CLEAR`, input, 1: level. Returns CLOSED to IDLE.
- `VOTE_EN`, output, 1: high exactly while in OPEN.
- `TICK_1S`, output, 1: one-cycle pulse per elapsed second while OPEN.
- `SECS_LEFT`, output, SEC_W: seconds remaining in the session.
- `DONE`, output, 1: one-cycle pulse on entry to CLOSED.
- `ABORTED`, output, 1: sticky. Set when CLOSED was reached via `ABORT`.

## Operation
- States: IDLE, OPEN, CLOSED. All outputs are registered.
- Reset (`RST_N`=0 at an edge) sets the following:
  - state = IDLE
  - `VOTE_EN`=0, `TICK_1S`=0, `DONE`=0, `ABORTED`=0
  - `SECS_LEFT`=0, prescaler=0
- Reset applies from any state, including mid-session, and overrides all inputs.
- IDLE:
  - `START`=1 → OPEN. Load `SECS_LEFT`=SESSION_SECS, clear prescaler, clear `ABORTED`.
  - `ABORT` and `CLEAR` are ignored.
- OPEN:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - `TICK_1S` is high in the cycle where prescaler = TICKS_PER_SEC-1.
  - At the edge ending a tick cycle, `SECS_LEFT` decrements.
  - If `SECS_LEFT` was 1 at that edge → CLOSED, with `SECS_LEFT`=0.
  - `ABORT`=1 → CLOSED immediately. Set `ABORTED`=1 and freeze `SECS_LEFT` at its current value.
  - `START` is ignored.
- CLOSED:
  - `VOTE_EN`=0, prescaler held at 0, `TICK_1S`=0.
  - `CLEAR`=1 → IDLE, `SECS_LEFT`=0. `ABORTED` is kept until the next `START`.
  - `START` and `ABORT` are ignored.
- Simultaneous events:
  - `ABORT` on the final tick edge: the abort takes priority, so `ABORTED`=1 and `SECS_LEFT`=0.
  - `START` with `CLEAR` in CLOSED: go to IDLE only. A new session requires `START` on a later edge.
- Width rules:
  - `SECS_LEFT` never underflows.
  - Prescaler width is $clog2(TICKS_PER_SEC).
  - SESSION_SECS > 2^SEC_W-1 is a parameter error; flag it with an elaboration-time check.

## Timing
- `START` is sampled at edge k. `VOTE_EN`=1 and `SECS_LEFT`=SESSION_SECS from cycle k+1, called "cycle 1".
- `TICK_1S` is high in cycles n·TICKS_PER_SEC, for n = 1..SESSION_SECS.
- `SECS_LEFT` = SESSION_SECS−n from cycle n·TICKS_PER_SEC+1.
- Normal close happens at cycle SESSION_SECS·TICKS_PER_SEC + 1:
  - `VOTE_EN`=0.
  - `DONE`=1 for exactly that cycle.
- `ABORT` sampled at edge m: `VOTE_EN`=0, `DONE`=1 and `ABORTED`=1 in cycle m+1. No `TICK_1S` from cycle m+1 on.
- `CLEAR` sampled at edge c: IDLE in cycle c+1. The earliest new `START` is sampled at edge c+1.
- Latency from any input to any output is one cycle. There are no combinational input→output paths.

## Structure
- Shared package `evote_pkg`:
  - State encoding constants: `ST_IDLE`=2'd0, `ST_OPEN`=2'd1, `ST_CLOSED`=2'd2.
  - Default `TICKS_PER_SEC` and `SESSION_SECS`, so the tally and display blocks use the same values.
- One sub-module, `tick_prescaler`:
  - Parameter TICKS.
  - Ports `CLK`, `RST_N`, `EN`, `CLR`, `TICK`.
  - Registered wrap counter.
  - Instantiated once, with `EN`=(state==OPEN) and `CLR` on entry to OPEN.
- Top level: FSM, `SECS_LEFT` down-counter, `DONE`/`ABORTED` registers.
- The bench drives `CLK` from `ClockGen`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4 and `SESSION_SECS`=3 unless stated.
- **Reset:** hold `RST_N`=0 for 3 edges with `START`=1 → all outputs are 0, state is IDLE, and `VOTE_EN` never rises.
- **Full session:** 1-cycle `START` → `VOTE_EN` is high for cycles 1–12. `TICK_1S` is high in cycles 4, 8, 12. `SECS_LEFT` runs 3,3,3,3,2,…,1, then 0 from cycle 13. `DONE`=1 only in cycle 13.
- **Abort mid-session:** `ABORT` at edge 6 → `SECS_LEFT` is frozen at 2, `DONE`=1 and `ABORTED`=1 in cycle 7, `VOTE_EN`=0. A following `CLEAR` then `START` → `ABORTED` returns to 0 and `SECS_LEFT`=3.
- **Abort on final tick:** `ABORT` asserted in cycle 12 → `SECS_LEFT`=0, `ABORTED`=1, and a single `DONE` pulse in cycle 13.
- **Ignored inputs:** `START` held high throughout OPEN does not reload `SECS_LEFT`. `CLEAR` during OPEN has no effect. `START`+`CLEAR` in CLOSED → IDLE, and no new session opens that cycle.
- **Reset mid-session:** `RST_N`=0 at edge 5 → IDLE from cycle 6, with `SECS_LEFT`=0, `VOTE_EN`=0, and no `DONE` pulse.
